// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame scheduler: FSM states,
// framing bytes and frame-length helper.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [7:0] HDR_S = 8'h53;
  localparam logic [7:0] HDR_T = 8'h54;
  localparam logic [7:0] TRL_E = 8'h45;
  localparam logic [7:0] TRL_N = 8'h4E;
  localparam logic [7:0] TRL_D = 8'h44;

  // Byte index width; covers the longest frame (15 points -> 66 bytes).
  localparam int unsigned IDX_W = 7;

  function automatic int unsigned frame_len(input int unsigned num_points);
    return 4 * num_points + 6;
  endfunction

endpackage

// File: rtl/uart_frame_byte_sel.sv
// Combinational selection of the frame byte at a given index from the
// snapshotted points and the running checksum.
module uart_frame_byte_sel
  import uart_frame_pkg::*;
#(
  parameter int unsigned NUM_POINTS = 8
) (
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [16*NUM_POINTS-1:0] snap_h_i,
  input  logic [16*NUM_POINTS-1:0] snap_v_i,
  input  logic [7:0]              chk_i,
  output logic [7:0]              byte_o
);

  localparam int unsigned CHK_IDX = 4 * NUM_POINTS + 2;

  always_comb begin
    byte_o = '0;
    if (idx_i == IDX_W'(0)) begin
      byte_o = HDR_S;
    end else if (idx_i == IDX_W'(1)) begin
      byte_o = HDR_T;
    end else if (idx_i == IDX_W'(CHK_IDX)) begin
      byte_o = chk_i;
    end else if (idx_i == IDX_W'(CHK_IDX + 1)) begin
      byte_o = TRL_E;
    end else if (idx_i == IDX_W'(CHK_IDX + 2)) begin
      byte_o = TRL_N;
    end else if (idx_i == IDX_W'(CHK_IDX + 3)) begin
      byte_o = TRL_D;
    end else begin
      for (int unsigned i = 0; i < NUM_POINTS; i++) begin
        if (idx_i == IDX_W'(4 * i + 2)) byte_o = snap_h_i[16*i+8 +: 8];
        if (idx_i == IDX_W'(4 * i + 3)) byte_o = snap_h_i[16*i   +: 8];
        if (idx_i == IDX_W'(4 * i + 4)) byte_o = snap_v_i[16*i+8 +: 8];
        if (idx_i == IDX_W'(4 * i + 5)) byte_o = snap_v_i[16*i   +: 8];
      end
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Streams snapshotted point coordinates as checksummed frames over the
// shared UART transmitter's DV/ACTIVE/DONE handshake, with a per-byte watchdog.
module uart_frame_scheduler
  import uart_frame_pkg::*;
#(
  parameter int unsigned NUM_POINTS  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  input  logic                     FRAME_TRIG,
  input  logic [16*NUM_POINTS-1:0] POINTS_H,
  input  logic [16*NUM_POINTS-1:0] POINTS_V,
  input  logic                     TX_ACTIVE,
  input  logic                     TX_DONE,
  output logic                     TX_DV,
  output logic [7:0]               TX_BYTE,
  output logic                     BUSY,
  output logic                     FRAME_DONE,
  output logic                     TX_ERR,
  output logic [7:0]               DROP_CNT
);

  localparam int unsigned LAST_IDX = frame_len(NUM_POINTS) - 1;
  localparam int unsigned PAY_HI   = 4 * NUM_POINTS + 1;
  localparam int unsigned WD_W     = $clog2(TIMEOUT_CYC + 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [7:0]                chk_q, chk_d;
  logic [16*NUM_POINTS-1:0]  snap_h_q, snap_h_d;
  logic [16*NUM_POINTS-1:0]  snap_v_q, snap_v_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [7:0]                drop_q, drop_d;
  logic [7:0]                sel_byte;

  uart_frame_byte_sel #(
    .NUM_POINTS(NUM_POINTS)
  ) u_byte_sel (
    .idx_i   (idx_q),
    .snap_h_i(snap_h_q),
    .snap_v_i(snap_v_q),
    .chk_i   (chk_q),
    .byte_o  (sel_byte)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      chk_q    <= '0;
      snap_h_q <= '0;
      snap_v_q <= '0;
      wd_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      snap_h_q <= snap_h_d;
      snap_v_q <= snap_v_d;
      wd_q     <= wd_d;
      done_q   <= done_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    snap_h_d = snap_h_q;
    snap_v_d = snap_v_q;
    wd_d     = wd_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    drop_d   = drop_q;

    // Any enabled trigger outside IDLE is lost, including one coinciding
    // with the final TX_DONE, since the FSM is still in WAIT that cycle.
    if (FRAME_TRIG && ENABLE && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (FRAME_TRIG && ENABLE) begin
          snap_h_d = POINTS_H;
          snap_v_d = POINTS_V;
          idx_d    = '0;
          chk_d    = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!TX_ACTIVE) begin
          wd_d    = WD_W'(1);
          state_d = ST_WAIT;
          if ((idx_q >= IDX_W'(2)) && (idx_q <= IDX_W'(PAY_HI))) begin
            chk_d = chk_q ^ sel_byte;
          end
        end
      end
      ST_WAIT: begin
        if (TX_DONE) begin
          if (idx_q == IDX_W'(LAST_IDX)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_ISSUE;
          end
        end else if (wd_q >= WD_W'(TIMEOUT_CYC)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    TX_DV      = (state_q == ST_ISSUE) && !TX_ACTIVE;
    BUSY       = (state_q != ST_IDLE);
    TX_BYTE    = (state_q == ST_IDLE) ? 8'h00 : sel_byte;
    FRAME_DONE = done_q;
    TX_ERR     = err_q;
    DROP_CNT   = drop_q;
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed self-checking bench for uart_frame_scheduler (8 points, 50-cycle watchdog).
module tb_uart_frame_scheduler;

  localparam int NP   = 8;
  localparam int FLEN = 4 * NP + 6;

  logic            CLK = 1'b0;
  logic            RST;
  logic            ENABLE;
  logic            FRAME_TRIG;
  logic [16*NP-1:0] POINTS_H;
  logic [16*NP-1:0] POINTS_V;
  logic            TX_ACTIVE;
  logic            TX_DONE;
  logic            TX_DV;
  logic [7:0]      TX_BYTE;
  logic            BUSY;
  logic            FRAME_DONE;
  logic            TX_ERR;
  logic [7:0]      DROP_CNT;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] ph [NP];
  logic [15:0] pv [NP];
  logic [7:0]  rx [64];
  int          rx_n;
  int          fd_mid;
  int          dv_to;
  int          unstable;

  always #5 CLK = ~CLK;

  uart_frame_scheduler #(
    .NUM_POINTS (NP),
    .TIMEOUT_CYC(50)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ENABLE    (ENABLE),
    .FRAME_TRIG(FRAME_TRIG),
    .POINTS_H  (POINTS_H),
    .POINTS_V  (POINTS_V),
    .TX_ACTIVE (TX_ACTIVE),
    .TX_DONE   (TX_DONE),
    .TX_DV     (TX_DV),
    .TX_BYTE   (TX_BYTE),
    .BUSY      (BUSY),
    .FRAME_DONE(FRAME_DONE),
    .TX_ERR    (TX_ERR),
    .DROP_CNT  (DROP_CNT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int b);
    logic [7:0] x;
    int p;
    int s;
    if (b == 0) return 8'h53;
    if (b == 1) return 8'h54;
    if (b == FLEN - 4) begin
      x = 8'h00;
      for (int i = 0; i < NP; i++) x = x ^ ph[i][15:8] ^ ph[i][7:0] ^ pv[i][15:8] ^ pv[i][7:0];
      return x;
    end
    if (b == FLEN - 3) return 8'h45;
    if (b == FLEN - 2) return 8'h4E;
    if (b == FLEN - 1) return 8'h44;
    p = (b - 2) / 4;
    s = (b - 2) % 4;
    case (s)
      0: return ph[p][15:8];
      1: return ph[p][7:0];
      2: return pv[p][15:8];
      default: return pv[p][7:0];
    endcase
  endfunction

  task automatic apply_points();
    for (int i = 0; i < NP; i++) begin
      POINTS_H[16*i +: 16] = ph[i];
      POINTS_V[16*i +: 16] = pv[i];
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge of the first cycle after acceptance.
  task automatic do_trig(input logic act);
    ENABLE     = 1'b1;
    FRAME_TRIG = 1'b1;
    TX_ACTIVE  = act;
    @(negedge CLK);
    FRAME_TRIG = 1'b0;
  endtask

  // Serializer model: TX_DONE ten cycles after each TX_DV. Returns at the
  // negedge after the final TX_DONE, or at the TX_DV negedge of byte hold_at.
  task automatic serve_frame(input int hold_at, input logic [63:0] trig_mask,
                             input logic trig_final, input int corrupt_at);
    int n;
    rx_n = 0; fd_mid = 0; dv_to = 0; unstable = 0;
    for (int b = 0; b < FLEN; b++) begin
      n = 0;
      while (TX_DV !== 1'b1 && n < 100) begin
        if (FRAME_DONE === 1'b1) fd_mid++;
        @(negedge CLK);
        n++;
      end
      if (TX_DV !== 1'b1) begin
        dv_to = 1;
        return;
      end
      rx[b] = TX_BYTE;
      rx_n++;
      if (b == hold_at) return;
      if (trig_mask[b]) FRAME_TRIG = 1'b1;
      if (b == corrupt_at) begin
        POINTS_H = '1;
        POINTS_V = '1;
      end
      for (int c = 0; c < 9; c++) begin
        @(negedge CLK);
        FRAME_TRIG = 1'b0;
        if (FRAME_DONE === 1'b1) fd_mid++;
        if (TX_BYTE !== rx[b] || TX_DV !== 1'b0) unstable++;
      end
      TX_DONE = 1'b1;
      if (b == FLEN - 1 && trig_final) FRAME_TRIG = 1'b1;
      @(negedge CLK);
      TX_DONE    = 1'b0;
      FRAME_TRIG = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_dv_timeout"}, dv_to, 0);
    check({tag, "_nbytes"}, rx_n, FLEN);
    check({tag, "_byte_stable"}, unstable, 0);
    check({tag, "_mid_frame_done"}, fd_mid, 0);
    for (int b = 0; b < rx_n; b++) check($sformatf("%s_byte%0d", tag, b), rx[b], exp_byte(b));
  endtask

  initial begin
    int n;
    int seen;
    RST = 1'b1; ENABLE = 1'b0; FRAME_TRIG = 1'b0; TX_ACTIVE = 1'b0; TX_DONE = 1'b0;
    for (int i = 0; i < NP; i++) begin ph[i] = 16'h0; pv[i] = 16'h0; end
    ph[0] = 16'h0123; pv[0] = 16'h0456;
    apply_points();

    repeat (3) @(negedge CLK);
    check("rst_tx_dv", TX_DV, 1'b0);
    check("rst_tx_byte", TX_BYTE, 8'h00);
    check("rst_busy", BUSY, 1'b0);
    check("rst_frame_done", FRAME_DONE, 1'b0);
    check("rst_tx_err", TX_ERR, 1'b0);
    check("rst_drop_cnt", DROP_CNT, 8'h00);
    RST = 1'b0;
    @(negedge CLK);

    // Trigger with ENABLE low: ignored, not counted
    ENABLE = 1'b0; FRAME_TRIG = 1'b1;
    @(negedge CLK);
    FRAME_TRIG = 1'b0;
    check("dis_busy", BUSY, 1'b0);
    check("dis_drop_cnt", DROP_CNT, 8'h00);
    @(negedge CLK);

    // Single frame
    do_trig(1'b0);
    check("f1_busy", BUSY, 1'b1);
    check("f1_first_dv", TX_DV, 1'b1);
    check("f1_first_byte", TX_BYTE, 8'h53);
    serve_frame(-1, 64'd0, 1'b0, -1);
    check_frame("f1");
    check("f1_chk", rx[34], 8'h70);
    check("f1_frame_done", FRAME_DONE, 1'b1);
    check("f1_busy_end", BUSY, 1'b0);
    @(negedge CLK);
    check("f1_frame_done_pulse", FRAME_DONE, 1'b0);

    // Snapshot isolation: inputs go to all ones after byte 5
    do_trig(1'b0);
    serve_frame(-1, 64'd0, 1'b0, 5);
    check_frame("snap");
    check("snap_chk", rx[34], 8'h70);
    check("snap_frame_done", FRAME_DONE, 1'b1);
    apply_points();
    @(negedge CLK);

    // Busy drops: three mid-frame plus one on the final TX_DONE
    do_trig(1'b0);
    serve_frame(-1, (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 20), 1'b1, -1);
    check_frame("drop");
    check("drop_frame_done", FRAME_DONE, 1'b1);
    check("drop_cnt", DROP_CNT, 8'd4);

    // Next-cycle trigger accepted, then 20 cycles of backpressure
    do_trig(1'b1);
    check("bp_busy", BUSY, 1'b1);
    check("bp_drop_cnt_hold", DROP_CNT, 8'd4);
    seen = (TX_DV === 1'b1) ? 1 : 0;
    for (int c = 0; c < 19; c++) begin
      @(negedge CLK);
      if (TX_DV !== 1'b0) seen++;
    end
    check("bp_dv_held_low", seen, 0);
    TX_ACTIVE = 1'b0;
    #1;
    check("bp_dv_release", TX_DV, 1'b1);
    check("bp_byte_release", TX_BYTE, 8'h53);
    serve_frame(-1, 64'd0, 1'b0, -1);
    check_frame("bp");
    check("bp_frame_done", FRAME_DONE, 1'b1);
    @(negedge CLK);

    // Watchdog: no TX_DONE for byte 3
    do_trig(1'b0);
    serve_frame(3, 64'd0, 1'b0, -1);
    check("wd_dv_timeout", dv_to, 0);
    check("wd_byte3", rx[3], 8'h23);
    n = 0; seen = 0;
    while (TX_ERR !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
      if (FRAME_DONE === 1'b1) seen++;
    end
    check("wd_err_latency", n, 51);
    check("wd_busy", BUSY, 1'b0);
    check("wd_no_frame_done", seen, 0);
    @(negedge CLK);
    check("wd_err_pulse", TX_ERR, 1'b0);
    check("wd_idle_dv", TX_DV, 1'b0);

    // Reset at byte 20
    do_trig(1'b0);
    serve_frame(20, 64'd0, 1'b0, -1);
    check("mr_dv_timeout", dv_to, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("mr_tx_dv", TX_DV, 1'b0);
    check("mr_tx_byte", TX_BYTE, 8'h00);
    check("mr_busy", BUSY, 1'b0);
    check("mr_frame_done", FRAME_DONE, 1'b0);
    check("mr_tx_err", TX_ERR, 1'b0);
    check("mr_drop_cnt", DROP_CNT, 8'h00);
    do_trig(1'b0);
    check("mr_restart_dv", TX_DV, 1'b1);
    check("mr_restart_byte", TX_BYTE, 8'h53);
    serve_frame(-1, 64'd0, 1'b0, -1);
    check_frame("mr");
    check("mr_frame_done_end", FRAME_DONE, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_scheduler.md
# uart_frame_scheduler

Sequencer that owns the shared UART transmitter and streams point-tracker results to the host as framed packets. On each frame trigger it snapshots all point coordinates and feeds the serial transmitter one byte at a time over its DV/ACTIVE/DONE handshake. The frame carries a checksum and is bounded by a per-byte watchdog. It sits between the blob/point detector outputs and the `uart_tx` serializer, replacing free-running byte selection clocked by `TX_DONE`.

## Interface
- `NUM_POINTS`, default 8: number of (H,V) points per frame, range 1–15.
- `TIMEOUT_CYC`, default 100000: maximum cycles to wait for `TX_DONE` after a `TX_DV` pulse.
- `CLK` in 1: system clock; one clock domain only.
- `RST` in 1: reset, synchronous and active-high.
- `ENABLE` in 1: when low, triggers are ignored; a frame already in flight completes.
- `FRAME_TRIG` in 1: single-cycle request to send a frame (e.g. vsync edge).
- `POINTS_H` in 16*NUM_POINTS: point i H coordinate at bits [16i+15:16i].
- `POINTS_V` in 16*NUM_POINTS: point i V coordinate at bits [16i+15:16i].
- `TX_ACTIVE` in 1: serializer busy.
- `TX_DONE` in 1: serializer one-cycle pulse at end of byte.
- `TX_DV` out 1: one-cycle byte-valid strobe to serializer.
- `TX_BYTE` out 8: byte to send; stable from the `TX_DV` cycle until the matching `TX_DONE`.
- `BUSY` out 1: a frame is in flight.
- `FRAME_DONE` out 1: one-cycle pulse after the last byte's `TX_DONE`.
- `TX_ERR` out 1: one-cycle pulse on watchdog abort.
- `DROP_CNT` out 8: saturating count of triggers rejected while busy.

## Operation
- Frame byte order, length L = 4*NUM_POINTS + 6 (38 for the default):
  - `S`(0x53), `T`(0x54).
  - For each point i = 0..N-1: H[15:8], H[7:0], V[15:8], V[7:0].
  - CHK: XOR of all 4N payload bytes.
  - `E`(0x45), `N`(0x4E), `D`(0x44).
- Snapshot: all points are registered in the accept cycle. Input changes mid-frame do not affect the frame.
- CHK is accumulated incrementally as payload bytes are issued (8-bit running XOR, cleared at frame start).
- State machine:
  - IDLE: if `FRAME_TRIG` and `ENABLE`, snapshot, clear byte index and CHK, go to ISSUE.
  - ISSUE: if `TX_ACTIVE` is low, pulse `TX_DV` with the current byte, clear the watchdog, go to WAIT. Otherwise hold in ISSUE.
  - WAIT: on `TX_DONE`, either go to ISSUE with index+1, or, if index = L-1, pulse `FRAME_DONE` and go to IDLE. If the watchdog reaches `TIMEOUT_CYC`, pulse `TX_ERR` and go to IDLE with the frame abandoned.
- A `FRAME_TRIG` while `BUSY` is high, or in the same cycle as the final `TX_DONE`, is dropped and increments `DROP_CNT`. The counter saturates at 255. There is no queueing.
- `FRAME_TRIG` while `ENABLE` is low is ignored and not counted.
- A `TX_DONE` seen in IDLE or ISSUE is ignored.

## Timing
- Reset values: `TX_DV`=0, `TX_BYTE`=0x00, `BUSY`=0, `FRAME_DONE`=0, `TX_ERR`=0, `DROP_CNT`=0, state IDLE, index 0, CHK 0.
- Trigger accepted at edge n: `BUSY`=1 and `TX_DV`=1 with `TX_BYTE`=0x53 in cycle n+1 (assuming `TX_ACTIVE`=0).
- `TX_DONE` at edge k: next `TX_DV` in cycle k+1, provided `TX_ACTIVE` is low.
- Final `TX_DONE` at edge k: `FRAME_DONE`=1 and `BUSY`=0 in cycle k+1. A new trigger is accepted from edge k+1.
- Watchdog counts from the cycle after `TX_DV`. `TX_ERR` is asserted in the cycle after the count reaches `TIMEOUT_CYC`, with `BUSY` falling in the same cycle.
- `RST` mid-frame: all outputs return to reset values on the next edge. Any byte still shifting in the serializer is not tracked.

## Structure
- Package `uart_frame_pkg` holds:
  - state encoding (IDLE, ISSUE, WAIT);
  - header/trailer byte constants;
  - a frame-length function of `NUM_POINTS`.
- Byte selection is a natural sub-module, `uart_frame_byte_sel`: a combinational mux from (index, snapshot, CHK) to byte.
- Everything else stays in the top module.

## Test plan
- Single frame, default N: P0 = (0x0123, 0x0456), all other points 0, `TX_DONE` 10 cycles after each `TX_DV`.
  - Expect 38 bytes in order: 53 54 01 23 04 56 00… CHK=0x70, then 45 4E 44.
  - Expect one `FRAME_DONE` pulse.
- Snapshot isolation: change all points to 0xFFFF after byte 5. Frame payload is unchanged and CHK=0x70.
- Busy drop: three `FRAME_TRIG` pulses mid-frame plus one coinciding with the final `TX_DONE`.
  - `DROP_CNT`=4 and exactly one frame is sent.
  - A trigger one cycle later is accepted.
- Backpressure: hold `TX_ACTIVE`=1 for 20 cycles in ISSUE. `TX_DV` stays low, then pulses on the first cycle after `TX_ACTIVE` falls.
- Watchdog: `TIMEOUT_CYC`=50 and withhold `TX_DONE` after byte 3. `TX_ERR` pulses 51 cycles after that `TX_DV`, `BUSY`=0, and no `FRAME_DONE` is seen.
- Reset mid-frame: assert `RST` one cycle at byte 20. Outputs return to reset values next cycle, and a new trigger restarts the frame at 0x53.
